// File: rtl/dsp48a1_mac_seq_if.sv
// Handshake, run-control and slice-facing signals of the DSP48A1 MAC sequencer.
// slave = the sequencer itself, master = the operand source / result sink / slice side.
interface dsp48a1_mac_seq_if #(
  parameter int LEN_WIDTH = 16
);
  logic                 start;
  logic [LEN_WIDTH-1:0] len;
  logic                 busy;
  logic                 s_valid;
  logic                 s_ready;
  logic [17:0]          s_a;
  logic [17:0]          s_b;
  logic [17:0]          dsp_a;
  logic [17:0]          dsp_b;
  logic [7:0]           dsp_opmode;
  logic [47:0]          dsp_p;
  logic                 res_valid;
  logic                 res_ready;
  logic [47:0]          res_data;

  modport slave (
    input  start, len, s_valid, s_a, s_b, res_ready, dsp_p,
    output busy, s_ready, dsp_a, dsp_b, dsp_opmode, res_valid, res_data
  );

  modport master (
    output start, len, s_valid, s_a, s_b, res_ready, dsp_p,
    input  busy, s_ready, dsp_a, dsp_b, dsp_opmode, res_valid, res_data
  );
endinterface

// File: rtl/dsp48a1_mac_seq.sv
// Streams (a, b) pairs into a DSP48A1 as a MAC, aligns OPMODE to the slice
// pipeline and returns the final P once the last product has landed.
//
// state | meaning
// IDLE  | waiting for start
// ACCUM | accepting operand pairs, issuing one per cycle
// DRAIN | all pairs issued, waiting for the last tag to leave the pipeline
// OUT   | res_data held, waiting for res_ready
module dsp48a1_mac_seq #(
  parameter int P_LATENCY    = 3,
  parameter int OPMODE_DELAY = 1,
  parameter int LEN_WIDTH    = 16
) (
  input  logic             CLK,
  input  logic             RST,
  dsp48a1_mac_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, OUT} state_t;

  localparam logic [7:0] OP_IDLE  = 8'h00;
  localparam logic [7:0] OP_FIRST = 8'h01;
  localparam logic [7:0] OP_ACC   = 8'h09;
  localparam logic [7:0] OP_HOLD  = 8'h08;

  state_t               state, state_next;
  logic [LEN_WIDTH-1:0] len_q;
  logic [LEN_WIDTH-1:0] issued_cnt;
  logic [LEN_WIDTH-1:0] cnt_inc;
  logic [17:0]          a_q, b_q;
  logic [7:0]           iss_op, op_next;
  logic                 iss_last;
  logic [P_LATENCY-1:0] tag_pipe;
  logic [47:0]          res_q;
  logic                 s_ready, accept, last_accept, tag_exit;

  assign cnt_inc     = issued_cnt + 1'b1;
  assign s_ready     = (state == ACCUM) && (issued_cnt < len_q);
  assign accept      = bus.s_valid && s_ready;
  assign last_accept = accept && (cnt_inc == len_q);
  assign tag_exit    = tag_pipe[P_LATENCY-1];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    op_next    = OP_IDLE;
    unique case (state)
      IDLE:    if (bus.start) state_next = (bus.len == '0) ? OUT : ACCUM;
      ACCUM:   if (last_accept) state_next = DRAIN;
      DRAIN:   if (tag_exit) state_next = OUT;
      OUT:     if (bus.res_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // opcode describes the cycle that follows this edge, i.e. the issue cycle
    if (accept)
      op_next = (issued_cnt == '0) ? OP_FIRST : OP_ACC;
    else if (state_next == ACCUM || state_next == DRAIN)
      op_next = OP_HOLD;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      len_q      <= '0;
      issued_cnt <= '0;
      a_q        <= '0;
      b_q        <= '0;
      iss_op     <= OP_IDLE;
      iss_last   <= 1'b0;
      tag_pipe   <= '0;
      res_q      <= '0;
    end else begin
      if (state == IDLE && bus.start) begin
        len_q      <= bus.len;
        issued_cnt <= '0;
      end else if (accept) begin
        issued_cnt <= cnt_inc;
      end
      a_q      <= accept ? bus.s_a : '0;
      b_q      <= accept ? bus.s_b : '0;
      iss_op   <= op_next;
      iss_last <= last_accept;
      tag_pipe[0] <= iss_last;
      for (int i = 1; i < P_LATENCY; i++) tag_pipe[i] <= tag_pipe[i-1];
      if (state == IDLE && bus.start && bus.len == '0)
        res_q <= '0;
      else if (state == DRAIN && tag_exit)
        res_q <= bus.dsp_p;
    end
  end

  // the slice registers OPMODE once more, so it must trail the operands
  generate
    if (OPMODE_DELAY == 0) begin : g_op_direct
      assign bus.dsp_opmode = iss_op;
    end else begin : g_op_pipe
      logic [7:0] op_pipe [OPMODE_DELAY];
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          for (int i = 0; i < OPMODE_DELAY; i++) op_pipe[i] <= OP_IDLE;
        end else begin
          op_pipe[0] <= iss_op;
          for (int i = 1; i < OPMODE_DELAY; i++) op_pipe[i] <= op_pipe[i-1];
        end
      end
      assign bus.dsp_opmode = op_pipe[OPMODE_DELAY-1];
    end
  endgenerate

  assign bus.busy      = (state != IDLE);
  assign bus.s_ready   = s_ready;
  assign bus.res_valid = (state == OUT);
  assign bus.res_data  = res_q;
  assign bus.dsp_a     = a_q;
  assign bus.dsp_b     = b_q;
endmodule

// File: tb/tb_dsp48a1_mac_seq.sv
// Sequencer driving a behavioural DSP48A1 (A1/B1/M/P/OPMODE registers, CE=1, RST=0),
// with a scoreboard of expected accumulated results.
module tb_dsp48a1_mac_seq;
  localparam int P_LATENCY = 3;
  localparam int LEN_WIDTH = 16;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;

  logic [47:0] exp_q [$];
  logic [17:0] pair_a [$];
  logic [17:0] pair_b [$];
  logic [7:0]  op_hist [1024];

  dsp48a1_mac_seq_if #(.LEN_WIDTH(LEN_WIDTH)) bus ();

  dsp48a1_mac_seq #(
    .P_LATENCY(P_LATENCY),
    .OPMODE_DELAY(1),
    .LEN_WIDTH(LEN_WIDTH)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;
  always @(negedge CLK) op_hist[cyc % 1024] <= bus.dsp_opmode;

  // slice model
  logic signed [17:0] m_a1 = '0;
  logic signed [17:0] m_b1 = '0;
  logic signed [35:0] m_m = '0;
  logic [7:0]         m_opm = '0;
  logic [47:0]        m_p = '0;

  always @(posedge CLK) begin
    m_a1  <= bus.dsp_a;
    m_b1  <= bus.dsp_b;
    m_m   <= m_a1 * m_b1;
    m_opm <= bus.dsp_opmode;
    m_p   <= ((m_opm[3:2] == 2'b10) ? m_p : 48'd0) +
             ((m_opm[1:0] == 2'b01) ? {{12{m_m[35]}}, m_m} : 48'd0);
  end
  assign bus.dsp_p = m_p;

  function automatic logic [47:0] sum_products();
    logic signed [47:0] s, pa, pb;
    s = '0;
    for (int i = 0; i < pair_a.size(); i++) begin
      pa = $signed(pair_a[i]);
      pb = $signed(pair_b[i]);
      s  = s + pa * pb;
    end
    return s;
  endfunction

  task automatic do_start(input logic [LEN_WIDTH-1:0] l);
    bus.len   = l;
    bus.start = 1'b1;
    @(posedge CLK); #1;
    bus.start = 1'b0;
  endtask

  task automatic send_pairs(input int gap, output int first_acc, output bit to);
    int w;
    first_acc = -1;
    to = 1'b0;
    for (int i = 0; i < pair_a.size(); i++) begin
      bus.s_valid = 1'b1;
      bus.s_a = pair_a[i];
      bus.s_b = pair_b[i];
      w = 0;
      @(negedge CLK);
      while (!bus.s_ready) begin
        w++;
        if (w > 50) begin
          to = 1'b1;
          bus.s_valid = 1'b0;
          @(posedge CLK); #1;
          return;
        end
        @(negedge CLK);
      end
      if (i == 0) first_acc = cyc;
      @(posedge CLK); #1;
      bus.s_valid = 1'b0;
      bus.s_a = '0;
      bus.s_b = '0;
      repeat (gap) begin @(posedge CLK); #1; end
    end
  endtask

  task automatic wait_result(output logic [47:0] d, output int seen, output bit to);
    int w;
    w = 0;
    d = '0;
    seen = -1;
    to = 1'b0;
    @(negedge CLK);
    while (!bus.res_valid) begin
      w++;
      if (w > 200) begin
        to = 1'b1;
        @(posedge CLK); #1;
        return;
      end
      @(negedge CLK);
    end
    d = bus.res_data;
    seen = cyc;
    @(posedge CLK); #1;
  endtask

  task automatic test_reset();
    @(negedge CLK);
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_vec++; if (bus.s_ready !== 1'b0) begin n_err++; $display("FAIL reset_s_ready: got %b want 0", bus.s_ready); end
    n_vec++; if (bus.res_valid !== 1'b0) begin n_err++; $display("FAIL reset_res_valid: got %b want 0", bus.res_valid); end
    n_vec++; if (bus.dsp_a !== 18'd0) begin n_err++; $display("FAIL reset_dsp_a: got %h want 0", bus.dsp_a); end
    n_vec++; if (bus.dsp_b !== 18'd0) begin n_err++; $display("FAIL reset_dsp_b: got %h want 0", bus.dsp_b); end
    n_vec++; if (bus.res_data !== 48'd0) begin n_err++; $display("FAIL reset_res_data: got %h want 0", bus.res_data); end
    n_vec++; if (bus.dsp_opmode !== 8'h00) begin n_err++; $display("FAIL reset_opmode: got %h want 00", bus.dsp_opmode); end
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL post_reset_busy: got %b want 0", bus.busy); end
    @(posedge CLK); #1;
  endtask

  task automatic test_back_to_back();
    logic [47:0] d, e;
    int t0, seen;
    bit to, to2;
    logic [7:0] exp_ops [4];
    exp_ops = '{8'h01, 8'h09, 8'h09, 8'h08};
    pair_a = '{18'd2, 18'd3, 18'd4};
    pair_b = '{18'd5, 18'd6, 18'd7};
    exp_q.push_back(sum_products());
    do_start(16'd3);
    send_pairs(0, t0, to);
    wait_result(d, seen, to2);
    n_vec++; if (to || to2) begin n_err++; $display("FAIL b2b_timeout: accept=%b result=%b want 0 0", to, to2); end
    e = exp_q.pop_front();
    n_vec++; if (d !== e) begin n_err++; $display("FAIL b2b_data: got %0d want %0d", d, e); end
    n_vec++; if (seen - t0 !== 3 + P_LATENCY + 1) begin n_err++; $display("FAIL b2b_latency: got %0d want %0d", seen - t0, 3 + P_LATENCY + 1); end
    for (int k = 0; k < 4; k++) begin
      n_vec++;
      if (op_hist[(t0 + 2 + k) % 1024] !== exp_ops[k]) begin
        n_err++;
        $display("FAIL b2b_opmode[%0d]: got %h want %h", k, op_hist[(t0 + 2 + k) % 1024], exp_ops[k]);
      end
    end
    @(negedge CLK);
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL b2b_busy_after: got %b want 0", bus.busy); end
    @(posedge CLK); #1;
  endtask

  task automatic test_bubbles();
    logic [47:0] d, e;
    int t0, seen;
    bit to, to2;
    logic [7:0] exp_ops [4];
    exp_ops = '{8'h01, 8'h08, 8'h08, 8'h09};
    pair_a = '{18'd2, 18'd3, 18'd4};
    pair_b = '{18'd5, 18'd6, 18'd7};
    exp_q.push_back(sum_products());
    do_start(16'd3);
    send_pairs(2, t0, to);
    wait_result(d, seen, to2);
    n_vec++; if (to || to2) begin n_err++; $display("FAIL bubble_timeout: accept=%b result=%b want 0 0", to, to2); end
    e = exp_q.pop_front();
    n_vec++; if (d !== e) begin n_err++; $display("FAIL bubble_data: got %0d want %0d", d, e); end
    n_vec++; if (seen - t0 !== 3 + 4 + P_LATENCY + 1) begin n_err++; $display("FAIL bubble_latency: got %0d want %0d", seen - t0, 3 + 4 + P_LATENCY + 1); end
    for (int k = 0; k < 4; k++) begin
      n_vec++;
      if (op_hist[(t0 + 2 + k) % 1024] !== exp_ops[k]) begin
        n_err++;
        $display("FAIL bubble_opmode[%0d]: got %h want %h", k, op_hist[(t0 + 2 + k) % 1024], exp_ops[k]);
      end
    end
  endtask

  task automatic test_consecutive();
    logic [47:0] d, e;
    int t0, seen;
    bit to, to2;
    pair_a = '{18'd10, 18'd1};
    pair_b = '{18'd10, 18'd1};
    exp_q.push_back(sum_products());
    do_start(16'd2);
    send_pairs(0, t0, to);
    wait_result(d, seen, to2);
    e = exp_q.pop_front();
    n_vec++; if (to || to2 || d !== e) begin n_err++; $display("FAIL run1_data: got %0d want %0d (timeouts %b %b)", d, e, to, to2); end
    pair_a = '{18'd3};
    pair_b = '{18'd3};
    exp_q.push_back(sum_products());
    do_start(16'd1);
    send_pairs(0, t0, to);
    wait_result(d, seen, to2);
    e = exp_q.pop_front();
    n_vec++; if (to || to2 || d !== e) begin n_err++; $display("FAIL run2_data: got %0d want %0d (timeouts %b %b)", d, e, to, to2); end
  endtask

  task automatic test_len_zero();
    logic [47:0] e;
    bit op_bad;
    exp_q.push_back(48'd0);
    op_bad = 1'b0;
    do_start(16'd0);
    @(negedge CLK);
    e = exp_q.pop_front();
    n_vec++; if (bus.res_valid !== 1'b1) begin n_err++; $display("FAIL len0_res_valid: got %b want 1", bus.res_valid); end
    n_vec++; if (bus.res_data !== e) begin n_err++; $display("FAIL len0_res_data: got %0d want %0d", bus.res_data, e); end
    n_vec++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL len0_busy: got %b want 1", bus.busy); end
    if (bus.dsp_opmode !== 8'h00) op_bad = 1'b1;
    @(posedge CLK); #1;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      if (bus.dsp_opmode !== 8'h00 || bus.res_valid !== 1'b0) op_bad = 1'b1;
    end
    n_vec++; if (op_bad) begin n_err++; $display("FAIL len0_opmode_idle: got nonzero opmode or res_valid want 00/0"); end
    @(posedge CLK); #1;
  endtask

  task automatic test_backpressure();
    logic [47:0] d, e;
    int t0, seen;
    bit to, to2, idle_bad;
    bus.res_ready = 1'b0;
    pair_a = '{18'd2, 18'd3, 18'd4};
    pair_b = '{18'd5, 18'd6, 18'd7};
    exp_q.push_back(sum_products());
    do_start(16'd3);
    send_pairs(0, t0, to);
    wait_result(d, seen, to2);
    n_vec++; if (to || to2 || d !== exp_q[0]) begin n_err++; $display("FAIL bp_first: got %0d want %0d (timeouts %b %b)", d, exp_q[0], to, to2); end
    for (int k = 0; k < 5; k++) begin
      bus.start = 1'b1;
      bus.len = 16'd1;
      @(negedge CLK);
      n_vec++; if (bus.res_valid !== 1'b1) begin n_err++; $display("FAIL bp_hold_valid[%0d]: got %b want 1", k, bus.res_valid); end
      n_vec++; if (bus.res_data !== exp_q[0]) begin n_err++; $display("FAIL bp_hold_data[%0d]: got %0d want %0d", k, bus.res_data, exp_q[0]); end
      n_vec++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL bp_hold_busy[%0d]: got %b want 1", k, bus.busy); end
      @(posedge CLK); #1;
    end
    bus.start = 1'b0;
    bus.res_ready = 1'b1;
    @(negedge CLK);
    e = exp_q.pop_front();
    n_vec++; if (bus.res_valid !== 1'b1 || bus.res_data !== e) begin n_err++; $display("FAIL bp_release: got valid=%b data=%0d want 1 %0d", bus.res_valid, bus.res_data, e); end
    @(posedge CLK); #1;
    idle_bad = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      if (bus.busy !== 1'b0 || bus.res_valid !== 1'b0 || bus.s_ready !== 1'b0) idle_bad = 1'b1;
    end
    n_vec++; if (idle_bad) begin n_err++; $display("FAIL bp_start_ignored: got busy/res_valid/s_ready active after handshake want idle"); end
    @(posedge CLK); #1;
  endtask

  task automatic test_reset_mid();
    logic [47:0] d, e;
    int t0, seen;
    bit to, to2, stray;
    pair_a = '{18'd1, 18'd3};
    pair_b = '{18'd2, 18'd4};
    do_start(16'd4);
    send_pairs(0, t0, to);
    #2;
    RST = 1'b1;
    #1;
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rst_mid_busy: got %b want 0", bus.busy); end
    n_vec++; if (bus.s_ready !== 1'b0) begin n_err++; $display("FAIL rst_mid_s_ready: got %b want 0", bus.s_ready); end
    n_vec++; if (bus.dsp_a !== 18'd0 || bus.dsp_b !== 18'd0) begin n_err++; $display("FAIL rst_mid_dsp_ab: got %0d %0d want 0 0", bus.dsp_a, bus.dsp_b); end
    n_vec++; if (bus.dsp_opmode !== 8'h00) begin n_err++; $display("FAIL rst_mid_opmode: got %h want 00", bus.dsp_opmode); end
    @(posedge CLK); #1;
    RST = 1'b0;
    stray = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge CLK);
      if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0) stray = 1'b1;
    end
    n_vec++; if (stray) begin n_err++; $display("FAIL rst_mid_no_result: got activity after abort want idle"); end
    @(posedge CLK); #1;
    pair_a = '{18'd7};
    pair_b = '{18'd8};
    exp_q.push_back(sum_products());
    do_start(16'd1);
    send_pairs(0, t0, to);
    wait_result(d, seen, to2);
    e = exp_q.pop_front();
    n_vec++; if (to || to2 || d !== e) begin n_err++; $display("FAIL rst_mid_rerun: got %0d want %0d (timeouts %b %b)", d, e, to, to2); end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.start = 1'b0;
    bus.len = '0;
    bus.s_valid = 1'b0;
    bus.s_a = '0;
    bus.s_b = '0;
    bus.res_ready = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    test_reset();
    test_back_to_back();
    test_bubbles();
    test_consecutive();
    test_len_zero();
    test_backpressure();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/dsp48a1_mac_seq.md
Name: dsp48a1_mac_seq

Overview:
Initiator-side sequencer that drives a DSP48A1 slice as a multiply-accumulate engine. It accepts a stream of (a, b) operand pairs over a valid/ready handshake. It presents each pair to the slice's A/B inputs with the correctly time-aligned OPMODE, and tracks the slice pipeline latency. It captures the final P value and returns it on a result valid/ready interface. Sits between a sample source (e.g. FIR/dot-product controller) and one DSP48A1 instance configured with A1REG=B1REG=MREG=PREG=OPMODEREG=1, A0REG=B0REG=0, CARRYINSEL="OPMODE5", B_INPUT="DIRECT".

Parameters:
P_LATENCY, 3, cycles from operand issue on dsp_a/dsp_b to the corresponding P visible on dsp_p
OPMODE_DELAY, 1, cycles between operand issue and the matching dsp_opmode value
LEN_WIDTH, 16, width of the run-length input

Ports:
CLK  in  1  clock, all logic rising-edge
RST  in  1  asynchronous, active-high reset
start  in  1  begin a run; sampled only in IDLE
len  in  LEN_WIDTH  number of operand pairs in the run; captured on start
busy  out  1  high in any state except IDLE
s_valid  in  1  operand pair valid
s_ready  out  1  sequencer accepts pair this cycle
s_a  in  18  operand A
s_b  in  18  operand B
dsp_a  out  18  to slice A
dsp_b  out  18  to slice B
dsp_opmode  out  8  to slice OPMODE
dsp_p  in  48  from slice P
res_valid  out  1  result valid
res_ready  in  1  result consumer ready
res_data  out  48  accumulated result

Behaviour:
- Reset: state IDLE; busy, s_ready, res_valid = 0; dsp_a, dsp_b, res_data = 0; dsp_opmode = 8'h00; all counters and tag pipelines cleared. Reset mid-run aborts the run; no result is emitted.
- States: IDLE -> (start & len!=0) ACCUM; IDLE -> (start & len==0) OUT with res_data=0 the next cycle. ACCUM -> DRAIN when the len-th pair is accepted. DRAIN -> OUT when the last tag exits the latency pipeline. OUT -> IDLE on res_valid & res_ready.
- s_ready = 1 only in ACCUM while issued count < len. A pair is accepted on s_valid & s_ready. It is registered onto dsp_a/dsp_b the same edge, so operands are issued in the cycle after acceptance.
- Per issue-cycle opcode: first pair of the run 8'h01 (X=M, Z=0). Subsequent pairs 8'h09 (X=M, Z=P). Bubble (no pair issued, including DRAIN) 8'h08 (X=0, Z=P, holds P). IDLE/OUT 8'h00. Bits 4..7 always 0 (no pre-adder, add, carry-in 0).
- dsp_opmode carries the issue-cycle opcode delayed by OPMODE_DELAY cycles through a shift register. The shift register resets to 8'h00.
- dsp_a/dsp_b are driven to 0 on bubble cycles.
- Tag pipeline: P_LATENCY-deep shift of a "last" bit, set on the issue cycle of the len-th pair. When the tag exits, capture dsp_p into res_data and enter OUT.
- OUT: res_valid held high; res_data stable until the handshake completes. start is ignored whenever busy=1.
- Issue counter: LEN_WIDTH bits; compares against the captured len; no wrap is possible within a run.
- Result is the raw 48-bit P; the sequencer performs no sign extension or saturation.
- Throughput: one pair per cycle; run time = len + P_LATENCY + 1 cycles minimum plus bubbles.

Test Plan:
- Bench: sequencer plus a DSP48A1 with the stated parameters, CE* tied 1, RST* of the slice tied 0.
- len=3, pairs (2,5),(3,6),(4,7) streamed back-to-back -> res_data=48'd56; dsp_opmode sequence 01,09,09,08...; res_valid rises len+P_LATENCY+1 cycles after the first accept.
- Same pairs with s_valid low for 2 cycles between every pair -> res_data=48'd56 (bubbles hold P via 8'h08).
- Two consecutive runs: len=2 (10,10),(1,1) giving 101, then len=1 (3,3) -> second res_data=9, not 110.
- len=0 with start -> res_valid one cycle later with res_data=0; no dsp_opmode other than 8'h00.
- res_ready low for 5 cycles in OUT -> res_valid and res_data=56 stable; start pulses in that window ignored; busy=1 until the handshake completes.
- RST asserted asynchronously mid-ACCUM -> outputs go to reset values immediately; a subsequent len=1 run with (7,8) returns 56.
